// File: rtl/door_motion_sequencer_pkg.sv
// Shared constants for the garage door motion sequencer: state codes and
// travel direction encodings. Optional feature macro: AUTO_CLOSE_EN.
package garage_door_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_MV_UP = 3'd1;
    localparam logic [2:0] ST_MV_DN = 3'd2;
    localparam logic [2:0] ST_DEAD  = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/door_motion_sequencer_if.sv
// Button/sensor inputs and motor/status outputs of the door sequencer.
// Optional feature macro: AUTO_CLOSE_EN (no effect on this interface).
//
// Handshake: there is no valid/ready pairing here. All inputs are plain
// levels sampled on every rising CLK edge; all outputs are Moore levels
// decoded from the state register and change only just after an edge.
interface door_motion_sequencer_if;
    logic       Activate;
    logic       UP_Max;
    logic       DN_Max;
    logic       Obstruct;
    logic       UP_M;
    logic       DN_M;
    logic       Fault;
    logic [2:0] St;

    // Environment side: drives button and sensors, observes the motors.
    modport master (
        output Activate, UP_Max, DN_Max, Obstruct,
        input  UP_M, DN_M, Fault, St
    );

    // Sequencer side.
    modport slave (
        input  Activate, UP_Max, DN_Max, Obstruct,
        output UP_M, DN_M, Fault, St
    );
endinterface

// File: rtl/door_motion_sequencer_cycle_timer.sv
// door_cycle_timer: clearable up-counter with enable and a terminal compare.
// Clear wins over enable. Optional feature macro: AUTO_CLOSE_EN (unused here).
module door_cycle_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term_val,
    output logic [CNT_W-1:0] count,
    output logic             at_term
);
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Next count: clear, increment or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count   = cnt_q;
    assign at_term = (cnt_q == term_val);
endmodule

// File: rtl/door_motion_sequencer.sv
// Garage door motion sequencer: edge-triggered push-button control of the
// UP/DN motor pair with obstruction reversal, travel watchdog and
// limit-switch conflict fault. Define AUTO_CLOSE_EN to close an open door
// automatically after AUTO_CLOSE_CYCLES of unobstructed idle time.
module door_motion_sequencer
    import garage_door_pkg::*;
#(
    parameter int CNT_W             = 16,
    parameter int DEAD_CYCLES       = 4,
    parameter int TRAVEL_TIMEOUT    = 1000,
    parameter int AUTO_CLOSE_CYCLES = 5000
) (
    input  logic                    CLK,
    input  logic                    RST,
    door_motion_sequencer_if.slave  io
);
    logic [2:0]       state_d, state_q;
    logic             last_dir_d, last_dir_q;
    logic             act_d, act_q;
    logic             act_rise;
    logic             limit_conflict;
    logic             auto_arm;
    logic             tmr_clr, tmr_en, tmr_at_term;
    logic [CNT_W-1:0] tmr_term, tmr_count;

    assign act_d          = io.Activate;
    assign act_rise       = io.Activate & ~act_q;
    assign limit_conflict = io.UP_Max & io.DN_Max;
    // Door fully open and beam clear: the only condition the idle dwell runs in.
    assign auto_arm       = io.UP_Max & ~io.Obstruct;

    // Next state and remembered direction, highest-priority rule first.
    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        if (limit_conflict) begin
            state_d = ST_FAULT;
        end else if ((state_q == ST_MV_UP || state_q == ST_MV_DN) && tmr_at_term) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (act_rise) begin
                        if (io.DN_Max)               state_d = ST_MV_UP;
                        else if (io.UP_Max)          state_d = ST_MV_DN;
                        else if (io.Obstruct)        state_d = ST_MV_UP;
                        else if (last_dir_q == DIR_DN) state_d = ST_MV_UP;
                        else                         state_d = ST_MV_DN;
                    end
`ifdef AUTO_CLOSE_EN
                    else if (auto_arm && tmr_at_term) begin
                        state_d = ST_MV_DN;
                    end
`endif
                end
                ST_MV_UP: begin
                    if (io.UP_Max || act_rise) state_d = ST_IDLE;
                end
                ST_MV_DN: begin
                    if (io.DN_Max)        state_d = ST_IDLE;
                    else if (io.Obstruct) state_d = ST_DEAD;
                    else if (act_rise)    state_d = ST_IDLE;
                end
                ST_DEAD: begin
                    if (tmr_at_term) state_d = ST_MV_UP;
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_FAULT;
            endcase
        end
        // Remember the direction of whichever travel state is being left.
        if (state_q == ST_MV_UP && state_d != ST_MV_UP) last_dir_d = DIR_UP;
        if (state_q == ST_MV_DN && state_d != ST_MV_DN) last_dir_d = DIR_DN;
    end

    // Timer control: per-state terminal value, enable and clear.
    always_comb begin
        tmr_term = CNT_W'(AUTO_CLOSE_CYCLES - 1);
        tmr_en   = 1'b0;
        tmr_clr  = (state_d != state_q);
        case (state_q)
            ST_MV_UP, ST_MV_DN: begin
                tmr_term = CNT_W'(TRAVEL_TIMEOUT - 1);
                tmr_en   = 1'b1;
            end
            ST_DEAD: begin
                tmr_term = CNT_W'(DEAD_CYCLES - 1);
                tmr_en   = 1'b1;
            end
            ST_IDLE: begin
`ifdef AUTO_CLOSE_EN
                tmr_en = auto_arm;
                if (!auto_arm) tmr_clr = 1'b1;
`else
                tmr_en = 1'b0;
`endif
            end
            default: tmr_en = 1'b0;
        endcase
    end

    door_cycle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (CLK),
        .rst      (RST),
        .clr      (tmr_clr),
        .en       (tmr_en),
        .term_val (tmr_term),
        .count    (tmr_count),
        .at_term  (tmr_at_term)
    );

    // State, direction and button-history registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            last_dir_q <= DIR_DN;
            act_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
            act_q      <= act_d;
        end
    end

    // Moore outputs decoded straight from the state register.
    assign io.UP_M  = (state_q == ST_MV_UP);
    assign io.DN_M  = (state_q == ST_MV_DN);
    assign io.Fault = (state_q == ST_FAULT);
    assign io.St    = state_q;
endmodule
